// File: rtl/rr_trace_split.sv
// Replay-side trace splitter: unpacks variable-width logging packets from the dense DRAM beat stream.
// Optional packet counter enabled by defining RR_TRACE_SPLIT_STATS_EN.
module rr_trace_split #(
    parameter int WIDTH            = 2500,
    parameter int AXI_WIDTH        = 512,
    parameter int OFFSET_WIDTH     = 32,
    parameter int LEN_WIDTH        = 16,
    parameter int PACKET_ALIGNMENT = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AXI_WIDTH-1:0]    beat_fifo_out,
    input  logic [OFFSET_WIDTH-1:0] beat_fifo_out_size,
    input  logic                    beat_fifo_out_last,
    input  logic                    beat_fifo_empty,
    output logic                    beat_fifo_rd_en,
    output logic [WIDTH-1:0]        pkt_fifo_in,
    output logic [OFFSET_WIDTH-1:0] pkt_fifo_in_width,
    output logic                    pkt_fifo_wr_en,
    input  logic                    pkt_fifo_almfull,
    output logic                    replay_done,
    output logic                    decode_err,
    output logic [OFFSET_WIDTH-1:0] pkt_count
);

    localparam int BUF_BITS = ((WIDTH + AXI_WIDTH - 1) / AXI_WIDTH + 1) * AXI_WIDTH;
    localparam int HDR_BITS = ((LEN_WIDTH + PACKET_ALIGNMENT - 1) / PACKET_ALIGNMENT) * PACKET_ALIGNMENT;
    localparam int NCHUNK   = (WIDTH + PACKET_ALIGNMENT - 1) / PACKET_ALIGNMENT;

    typedef enum logic [1:0] {S_FILL, S_DRAIN, S_DONE, S_ERR} state_t;

    state_t                  state_reg, state_next;
    logic [BUF_BITS-1:0]     buf_reg, buf_next, buf_shift, beat_ext, win_mask;
    logic [OFFSET_WIDTH-1:0] fill_reg, fill_next, fill_post;
    logic [LEN_WIDTH-1:0]    hdr_len_reg;
    logic                    hdr_valid_reg;
    logic [OFFSET_WIDTH-1:0] len_bits;
    logic                    hdr_bad, live, accept, emit;
    logic [WIDTH-1:0]        pkt_mask, pkt_data;
    logic [NCHUNK-1:0]       chunk_keep;

    logic                    pkt_fifo_wr_en_reg;
    logic [WIDTH-1:0]        pkt_fifo_in_reg;
    logic [OFFSET_WIDTH-1:0] pkt_fifo_in_width_reg;

    // Header fields are registered from the next-cycle buffer, so they always describe buf_reg.
    assign len_bits = OFFSET_WIDTH'(hdr_len_reg) * OFFSET_WIDTH'(PACKET_ALIGNMENT);
    assign hdr_bad  = hdr_valid_reg & ((hdr_len_reg == '0) | (len_bits > OFFSET_WIDTH'(WIDTH)));
    assign live     = (state_reg == S_FILL) | (state_reg == S_DRAIN);
    assign accept   = ~rst & (state_reg == S_FILL) & ~beat_fifo_empty
                    & (fill_reg + OFFSET_WIDTH'(AXI_WIDTH) <= OFFSET_WIDTH'(BUF_BITS));
    assign emit     = live & hdr_valid_reg & ~hdr_bad & (fill_reg >= len_bits) & ~pkt_fifo_almfull;

    assign beat_fifo_rd_en   = accept;
    assign pkt_fifo_wr_en    = pkt_fifo_wr_en_reg;
    assign pkt_fifo_in       = pkt_fifo_in_reg;
    assign pkt_fifo_in_width = pkt_fifo_in_width_reg;
    assign replay_done       = (state_reg == S_DONE);
    assign decode_err        = (state_reg == S_ERR);

    // Keep only the alignment chunks that belong to the current packet.
    genvar gi;
    generate
        for (gi = 0; gi < NCHUNK; gi++) begin : g_mask
            localparam int LO = gi * PACKET_ALIGNMENT;
            localparam int HI = (LO + PACKET_ALIGNMENT > WIDTH) ? WIDTH : LO + PACKET_ALIGNMENT;
            assign chunk_keep[gi]     = (LEN_WIDTH'(gi) < hdr_len_reg);
            assign pkt_mask[HI-1:LO]  = {(HI - LO){chunk_keep[gi]}};
        end
    endgenerate

    assign pkt_data = buf_reg[WIDTH-1:0] & pkt_mask;

    // Shift out the emitted packet first, then overwrite one beat-wide window at the new fill.
    always_comb begin
        fill_post = fill_reg;
        buf_shift = buf_reg;
        if (emit) begin
            fill_post = fill_reg - len_bits;
            buf_shift = buf_reg >> len_bits;
        end
        beat_ext  = {{(BUF_BITS - AXI_WIDTH){1'b0}}, beat_fifo_out};
        win_mask  = {{(BUF_BITS - AXI_WIDTH){1'b0}}, {AXI_WIDTH{1'b1}}} << fill_post;
        buf_next  = buf_shift;
        fill_next = fill_post;
        if (accept) begin
            buf_next  = (buf_shift & ~win_mask) | (beat_ext << fill_post);
            fill_next = fill_post + beat_fifo_out_size;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FILL: begin
                if (hdr_bad)
                    state_next = S_ERR;
                else if (accept & beat_fifo_out_last)
                    state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (hdr_bad)
                    state_next = S_ERR;
                else if (fill_reg == '0)
                    state_next = S_DONE;
                else if (~hdr_valid_reg | (fill_reg < len_bits))
                    state_next = S_ERR;
            end
            default: state_next = state_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg             <= S_FILL;
            fill_reg              <= '0;
            hdr_len_reg           <= '0;
            hdr_valid_reg         <= 1'b0;
            pkt_fifo_wr_en_reg    <= 1'b0;
            pkt_fifo_in_reg       <= '0;
            pkt_fifo_in_width_reg <= '0;
        end else begin
            state_reg          <= state_next;
            fill_reg           <= fill_next;
            hdr_len_reg        <= buf_next[LEN_WIDTH-1:0];
            hdr_valid_reg      <= (fill_next >= OFFSET_WIDTH'(HDR_BITS));
            pkt_fifo_wr_en_reg <= emit;
            if (emit) begin
                pkt_fifo_in_reg       <= pkt_data;
                pkt_fifo_in_width_reg <= len_bits;
            end
        end
    end

    // Buffer contents are meaningless while fill is zero, so no reset is needed here.
    always_ff @(posedge clk) begin
        buf_reg <= buf_next;
    end

`ifdef RR_TRACE_SPLIT_STATS_EN
    logic [OFFSET_WIDTH-1:0] pkt_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pkt_count_reg <= '0;
        else if (emit)
            pkt_count_reg <= pkt_count_reg + 1'b1;
    end

    assign pkt_count = pkt_count_reg;
`else
    assign pkt_count = '0;
`endif

    a_beat_size_legal: assert property (@(posedge clk) disable iff (rst)
        ((beat_fifo_out_size % OFFSET_WIDTH'(PACKET_ALIGNMENT)) == '0)
        && (beat_fifo_out_size <= OFFSET_WIDTH'(AXI_WIDTH)));

    a_partial_only_last: assert property (@(posedge clk) disable iff (rst)
        (beat_fifo_out_size < OFFSET_WIDTH'(AXI_WIDTH)) |-> beat_fifo_out_last);

endmodule
